quad_step_gen: RTL

- Quadrature step generator: moves an internal position register toward a loaded target one step at a time, at a programmable rate.
- Each step is emitted as a Gray-coded A/B phase advance, plus a step strobe and a direction flag.
- Acts as the transmit side for the team's up/down counters. `step_pulse`/`dir_up` drive a counter's enable/up inputs directly. `qa`/`qb` feed quadrature-input blocks.

---
 rtl/qsg_pkg.sv | 28 ++
 rtl/qsg_prescaler.sv | 35 +++
 rtl/quad_step_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/qsg_pkg.sv
// Shared types and helpers for the quadrature step generator.
// Optional index output is enabled with `define QSG_INDEX_EN.
package qsg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  // Gray-coded phase sequence, qa is the MSB.
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // One Gray step forward (up=1) or backward (up=0).
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic up);
    logic [1:0] nxt;
    case (phase)
      PH0:     nxt = up ? PH1 : PH3;
      PH1:     nxt = up ? PH2 : PH0;
      PH2:     nxt = up ? PH3 : PH1;
      default: nxt = up ? PH0 : PH2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qsg_prescaler.sv
// Step-rate prescaler: reloads from divisor on load or after each tick,
// otherwise counts down while run is high. Load has priority over tick.
module qsg_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] count;

  assign tick = run && !load && (count == '0);

  // Countdown register with reload on load and on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= divisor;
    end else if (run) begin
      if (count == '0) begin
        count <= divisor;
      end else begin
        count <= count - DIV_ONE;
      end
    end
  end

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature step generator: walks position toward a loaded target one
// Gray-coded phase step at a time, at a rate of one step per divisor+1 cycles.
// Optional feature: `define QSG_INDEX_EN adds the index_z output.
module quad_step_gen
  import qsg_pkg::*;
#(
  parameter int POS_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             target_load,
  input  logic [POS_W-1:0] target_value,
  input  logic [DIV_W-1:0] divisor,
  output logic             qa,
  output logic             qb,
  output logic             step_pulse,
  output logic             dir_up,
  output logic [POS_W-1:0] position,
  output logic             busy,
`ifdef QSG_INDEX_EN
  output logic             done,
  output logic             index_z
`else
  output logic             done
`endif
);

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t           state_q, state_d;
  logic [POS_W-1:0] target_q, target_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] pos_step;
  logic [1:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             tick;
  logic             run;
`ifdef QSG_INDEX_EN
  logic             index_q, index_d;
`endif

  assign run = enable && (state_q == MOVING);

  qsg_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .load    (target_load),
    .divisor (divisor),
    .tick    (tick)
  );

  assign pos_step = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

  // Next-state logic: a load pre-empts any step on the same edge.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pos_d    = pos_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
`ifdef QSG_INDEX_EN
    index_d  = 1'b0;
`endif
    if (target_load) begin
      target_d = target_value;
      if (target_value != pos_q) begin
        state_d = MOVING;
        dir_d   = (target_value > pos_q);
      end else begin
        state_d = IDLE;
      end
    end else if (tick) begin
      phase_d = next_phase(phase_q, dir_q);
      pos_d   = pos_step;
      step_d  = 1'b1;
`ifdef QSG_INDEX_EN
      index_d = (pos_step == '0);
`endif
      if (pos_step == target_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      pos_q    <= '0;
      phase_q  <= PH0;
      dir_q    <= 1'b1;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef QSG_INDEX_EN
      index_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      done_q   <= done_d;
`ifdef QSG_INDEX_EN
      index_q  <= index_d;
`endif
    end
  end

  assign qa         = phase_q[1];
  assign qb         = phase_q[0];
  assign step_pulse = step_q;
  assign dir_up     = dir_q;
  assign position   = pos_q;
  assign busy       = (state_q == MOVING);
  assign done       = done_q;
`ifdef QSG_INDEX_EN
  assign index_z    = index_q;
`endif

endmodule
